// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC trace capture block.
// Holds the capture FSM state type, default geometry constants and a
// constant-evaluable ceil(log2()) helper used to size counters and addresses.
package tdc_pkg;

  localparam int TDC_WIDTH_DEF = 128;
  localparam int DEPTH_DEF     = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } tdc_cap_state_t;

  // Smallest r with 2**r >= value (value >= 1)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Hamming weight of one raw thermometer-code TDC sample, registered.
// Ports:
//   clk    - sample clock
//   reset  - synchronous active-high reset, clears the registered weight
//   data   - TDC_WIDTH-bit sample
//   weight - CNT_W-bit population count of the sample seen one edge earlier
// Latency is exactly one clock; the full range 0..TDC_WIDTH is representable.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int TDC_WIDTH = TDC_WIDTH_DEF,
  parameter int CNT_W     = clog2(TDC_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TDC_WIDTH-1:0] data,
  output logic [CNT_W-1:0]     weight
);

  logic [CNT_W-1:0] sum;

  // Bit-count of the whole word; synthesis flattens the sum into a
  // compressor/adder tree, and the result is registered below.
  always_comb begin
    sum = '0;
    for (int i = 0; i < TDC_WIDTH; i++) begin
      sum = sum + CNT_W'(data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) weight <= '0;
    else       weight <= sum;
  end

endmodule

// File: rtl/tdc_trace_capture.sv
// TDC trace capture: converts each raw thermometer sample to a Hamming weight
// and stores DEPTH consecutive weights into an on-chip RAM, starting a
// programmable number of cycles after an AES start strobe.
// Ports:
//   clk, reset          - sample clock, synchronous active-high reset
//   tdc_in              - raw TDC sample, valid every cycle
//   arm                 - pulse: request a new capture (from IDLE or DONE)
//   trig, trig_delay    - start strobe and its delay, taken while ARMED
//   rd_en, rd_addr      - RAM read request (any state)
//   rd_data, rd_valid   - read result, one cycle after rd_en
//   armed, busy, done   - status flags
//   wr_count            - number of samples written in the current trace
module tdc_trace_capture
  import tdc_pkg::*;
#(
  parameter int TDC_WIDTH = TDC_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DELAY_W   = 16,
  parameter int CNT_W     = clog2(TDC_WIDTH + 1),
  parameter int AW        = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TDC_WIDTH-1:0] tdc_in,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [DELAY_W-1:0]   trig_delay,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [CNT_W-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 armed,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          wr_count
);

  tdc_cap_state_t state, state_next;

  logic [DELAY_W-1:0]   dly_cnt;
  logic [AW-1:0]        iss_cnt;
  logic [1:0]           we_pipe;
  logic                 issue;
  logic                 start_arm;
  logic                 load_delay;
  logic [TDC_WIDTH-1:0] tdc_q;
  logic [CNT_W-1:0]     weight;
  logic [AW-1:0]        wr_ptr;
  logic [CNT_W-1:0]     ram [DEPTH];

  assign wr_ptr   = wr_count[AW-1:0];
  assign armed    = (state == ST_ARMED);
  assign busy     = (state == ST_DELAY) || (state == ST_CAPTURE) || (state == ST_DRAIN);
  assign done     = (state == ST_DONE);

  // Next-state logic. Each CAPTURE cycle issues one write enable that
  // travels alongside its sample through the input register and the
  // popcount register. DRAIN waits until the last enable has left the
  // first pipeline stage; one cycle later it has been written.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    start_arm  = 1'b0;
    load_delay = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_next = ST_ARMED;
          start_arm  = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig) begin
          load_delay = 1'b1;
          state_next = (trig_delay == '0) ? ST_CAPTURE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (dly_cnt == DELAY_W'(1)) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        issue = 1'b1;
        if (iss_cnt == AW'(DEPTH - 1)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!we_pipe[0]) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, delay/issue counters, enable pipeline and write count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      dly_cnt  <= '0;
      iss_cnt  <= '0;
      we_pipe  <= '0;
      wr_count <= '0;
    end else begin
      state   <= state_next;
      we_pipe <= {we_pipe[0], issue};
      if (load_delay)             dly_cnt <= trig_delay;
      else if (state == ST_DELAY) dly_cnt <= dly_cnt - DELAY_W'(1);
      if (load_delay)             iss_cnt <= '0;
      else if (issue)             iss_cnt <= iss_cnt + AW'(1);
      if (start_arm)              wr_count <= '0;
      else if (we_pipe[1])        wr_count <= wr_count + (AW + 1)'(1);
    end
  end

  // Input sample register: first stage of the two-stage data path.
  always_ff @(posedge clk) begin
    if (reset) tdc_q <= '0;
    else       tdc_q <= tdc_in;
  end

  tdc_popcount #(
    .TDC_WIDTH (TDC_WIDTH),
    .CNT_W     (CNT_W)
  ) u_popcount (
    .clk    (clk),
    .reset  (reset),
    .data   (tdc_q),
    .weight (weight)
  );

  // Trace RAM write port. A write landing on the reset edge is suppressed so
  // that a mid-capture reset leaves the pipeline flushed without a stray write.
  always_ff @(posedge clk) begin
    if (we_pipe[1] && !reset) ram[wr_ptr] <= weight;
  end

  // Read port: registered, read-first against a same-edge write, and the
  // output holds its last value when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ram[rd_addr];
    end
  end

endmodule
